// File: rtl/arbiter_response_sampler_if.sv
// Interface between the arbiter PUF response sampler and the logic around it.
// It carries the request/response handshake and the two PDL chain connections.
interface arbiter_response_sampler_if #(
   parameter int CHAL_W = 64
);
   logic              start;
   logic [CHAL_W-1:0] challenge_top;
   logic [CHAL_W-1:0] challenge_btm;
   logic [CHAL_W-1:0] sel_top;
   logic [CHAL_W-1:0] sel_btm;
   logic              race_launch;
   logic              arb_out;
   logic              busy;
   logic              resp;
   logic              stable;
   logic              resp_valid;
   logic              resp_ready;

   // Requester / environment side: drives challenges, handshake and arbiter output.
   modport master (
      output start, challenge_top, challenge_btm, arb_out, resp_ready,
      input  sel_top, sel_btm, race_launch, busy, resp, stable, resp_valid
   );

   // Sampler side.
   modport slave (
      input  start, challenge_top, challenge_btm, arb_out, resp_ready,
      output sel_top, sel_btm, race_launch, busy, resp, stable, resp_valid
   );
endinterface

// File: rtl/arbiter_response_sampler.sv
// Arbiter PUF response sampler.
// It latches a challenge onto the two PDL chains and launches VOTES races.
// Each race has a settle phase and a relax phase. The arbiter output is
// sampled through a two-flop synchronizer, and the votes are reduced to a
// majority response plus a flag that says all votes agreed.
module arbiter_response_sampler #(
   parameter int CHAL_W        = 64,
   parameter int SETTLE_CYCLES = 8,
   parameter int VOTES         = 7
) (
   input logic                        clk,
   input logic                        reset,
   arbiter_response_sampler_if.slave  bus
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] VOTES_L     = 8'(VOTES);
   localparam logic [7:0] HALF_VOTES  = 8'(VOTES / 2);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LAUNCH,
      SETTLE,
      SAMPLE,
      RELAX,
      DONE
   } state_t;

   state_t            state_q,  state_d;
   logic [CHAL_W-1:0] sel_top_q, sel_top_d;
   logic [CHAL_W-1:0] sel_btm_q, sel_btm_d;
   logic              race_q,   race_d;
   logic              busy_q,   busy_d;
   logic              resp_q,   resp_d;
   logic              stable_q, stable_d;
   logic              valid_q,  valid_d;
   logic [7:0]        timer_q,  timer_d;
   logic [7:0]        vote_q,   vote_d;
   logic [7:0]        ones_q,   ones_d;
   logic              sync1_q,  sync1_d;
   logic              sync2_q,  sync2_d;

   // Next-state and next-output computation for the race sequencer.
   always_comb begin
      // NOTE: every signal gets a default here, so no path through the case leaves it unassigned and no latch is inferred.
      state_d   = state_q;
      sel_top_d = sel_top_q;
      sel_btm_d = sel_btm_q;
      race_d    = race_q;
      resp_d    = resp_q;
      stable_d  = stable_q;
      valid_d   = valid_q;
      timer_d   = timer_q;
      vote_d    = vote_q;
      ones_d    = ones_q;
      // arb_out is asynchronous to clk; only sync2 is used by the logic.
      sync1_d   = bus.arb_out;
      sync2_d   = sync1_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               sel_top_d = bus.challenge_top;
               sel_btm_d = bus.challenge_btm;
               vote_d    = '0;
               ones_d    = '0;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            // The selects have one cycle to settle before the edge is launched.
            race_d  = 1'b0;
            state_d = LAUNCH;
         end
         LAUNCH: begin
            race_d  = 1'b1;
            timer_d = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            if (timer_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         SAMPLE: begin
            ones_d  = ones_q + 8'(sync2_q);
            vote_d  = vote_q + 8'd1;
            race_d  = 1'b0;
            timer_d = '0;
            state_d = RELAX;
         end
         RELAX: begin
            if (timer_q == SETTLE_LAST) begin
               if (vote_q < VOTES_L) begin
                  state_d = LAUNCH;
               end else begin
                  resp_d   = (ones_q > HALF_VOTES);
                  stable_d = (ones_q == 8'd0) || (ones_q == VOTES_L);
                  valid_d  = 1'b1;
                  state_d  = DONE;
               end
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         DONE: begin
            // start is deliberately ignored here, including on the exit edge.
            if (bus.resp_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset wins over every input, mid-race included.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together from pre-edge values.
         state_q   <= IDLE;
         sel_top_q <= '0;
         sel_btm_q <= '0;
         race_q    <= 1'b0;
         busy_q    <= 1'b0;
         resp_q    <= 1'b0;
         stable_q  <= 1'b0;
         valid_q   <= 1'b0;
         timer_q   <= '0;
         vote_q    <= '0;
         ones_q    <= '0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_top_q <= sel_top_d;
         sel_btm_q <= sel_btm_d;
         race_q    <= race_d;
         busy_q    <= busy_d;
         resp_q    <= resp_d;
         stable_q  <= stable_d;
         valid_q   <= valid_d;
         timer_q   <= timer_d;
         vote_q    <= vote_d;
         ones_q    <= ones_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
      end
   end

   assign bus.sel_top     = sel_top_q;
   assign bus.sel_btm     = sel_btm_q;
   assign bus.race_launch = race_q;
   assign bus.busy        = busy_q;
   assign bus.resp        = resp_q;
   assign bus.stable      = stable_q;
   assign bus.resp_valid  = valid_q;

endmodule

// File: tb/tb_arbiter_response_sampler.sv
// Testbench for arbiter_response_sampler.
// A timeline model predicts every output from the number of edges since start
// was accepted and from the vote bits presented to the arbiter.
module tb_arbiter_response_sampler;
   localparam int CHAL_W  = 64;
   localparam int S       = 8;
   localparam int V       = 7;
   localparam int P       = 2 * S + 2;
   localparam int RUN_LEN = 1 + V * P;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arbiter_response_sampler_if #(.CHAL_W(CHAL_W)) bus ();

   arbiter_response_sampler #(
      .CHAL_W(CHAL_W), .SETTLE_CYCLES(S), .VOTES(V)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   bit              m_known = 1'b0;
   bit              m_run   = 1'b0;
   bit              m_done  = 1'b0;
   int              m_k     = 0;
   logic [CHAL_W-1:0] m_sel_top = '0;
   logic [CHAL_W-1:0] m_sel_btm = '0;
   bit              m_resp, m_stable, m_valid;
   bit              run_bits  [V];
   bit              next_bits [V];
   int              m_ones;

   // Launch is high from the first settle cycle through the sample cycle of each vote.
   function automatic bit exp_race(input bit run, input int k);
      int p;
      if (!run || k < 1) return 1'b0;
      p = (k - 1) % P;
      return (p >= 1) && (p <= S + 1);
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_known = 1'b1;
         m_run = 1'b0; m_done = 1'b0; m_k = 0;
         m_sel_top = '0; m_sel_btm = '0;
         m_resp = 1'b0; m_stable = 1'b0; m_valid = 1'b0;
      end else if (m_run) begin
         m_k++;
         if (m_k == RUN_LEN) begin
            m_ones = 0;
            foreach (run_bits[i]) m_ones += int'(run_bits[i]);
            m_run    = 1'b0;
            m_done   = 1'b1;
            m_valid  = 1'b1;
            m_resp   = (m_ones > V / 2);
            m_stable = (m_ones == 0) || (m_ones == V);
         end
      end else if (m_done) begin
         if (bus.resp_ready) begin
            m_done  = 1'b0;
            m_valid = 1'b0;
         end
      end else if (bus.start) begin
         m_run = 1'b1;
         m_k = 0;
         m_sel_top = bus.challenge_top;
         m_sel_btm = bus.challenge_btm;
         run_bits = next_bits;
      end
   end

   // Compare process: every cycle once reset has been applied.
   always @(posedge clk) begin
      #2;
      if (m_known) begin
         check("race_launch", 64'(bus.race_launch), 64'(exp_race(m_run, m_k)));
         check("busy",        64'(bus.busy),        64'(m_run || m_done));
         check("resp_valid",  64'(bus.resp_valid),  64'(m_valid));
         check("sel_top",     bus.sel_top,          m_sel_top);
         check("sel_btm",     bus.sel_btm,          m_sel_btm);
         if (m_valid) begin
            check("resp",   64'(bus.resp),   64'(m_resp));
            check("stable", 64'(bus.stable), 64'(m_stable));
         end
      end
   end

   // Arbiter stimulus: the vote bit is held through launch/settle/sample; noise while relaxing.
   always @(negedge clk) begin
      int p, v;
      if (m_run) begin
         if (m_k == 0) begin
            bus.arb_out = run_bits[0];
         end else begin
            p = (m_k - 1) % P;
            v = (m_k - 1) / P;
            bus.arb_out = (p >= S + 2) ? 1'($urandom % 2) : run_bits[v];
         end
      end else begin
         bus.arb_out = 1'($urandom % 2);
      end
   end

   // Race-launch pulse width monitor.
   int pulse_q[$];
   int cur_pulse = 0;
   always @(posedge clk) begin
      #3;
      if (bus.race_launch === 1'b1) cur_pulse++;
      else if (cur_pulse > 0) begin
         pulse_q.push_back(cur_pulse);
         cur_pulse = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic launch(input logic [CHAL_W-1:0] ct, input logic [CHAL_W-1:0] cb, output int acc_cyc);
      bus.challenge_top = ct;
      bus.challenge_btm = cb;
      bus.start = 1'b1;
      @(posedge clk);
      #1 acc_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(input bit spam, output int seen_cyc);
      seen_cyc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (spam) bus.start = 1'($urandom % 2);
         if (bus.resp_valid === 1'b1) begin
            seen_cyc = cyc;
            break;
         end
      end
      bus.start = 1'b0;
      if (seen_cyc < 0) check("resp_valid_timeout", 64'(bus.resp_valid), 64'd1);
   endtask

   // Wait until the handshake has completed and the sampler is idle again.
   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (!m_done && !m_run) break;
         @(negedge clk);
      end
   endtask

   task automatic set_bits(input logic [V-1:0] b);
      for (int i = 0; i < V; i++) next_bits[i] = b[i];
   endtask

   task automatic run_random();
      logic [V-1:0] b;
      int acc, rst_at;
      bit done_ok;
      b = V'($urandom);
      set_bits(b);
      launch({$urandom, $urandom}, {$urandom, $urandom}, acc);
      rst_at = ($urandom % 6 == 0) ? int'($urandom_range(1, RUN_LEN - 1)) : -1;
      done_ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (!m_run && !m_done) begin
            done_ok = 1'b1;
            break;
         end
         bus.start = 1'($urandom % 2);
         bus.resp_ready = ($urandom % 3 == 0);
         if ($urandom % 8 == 0) begin
            bus.challenge_top = {$urandom, $urandom};
            bus.challenge_btm = {$urandom, $urandom};
         end
         reset = (rst_at >= 0 && m_run && m_k == rst_at);
      end
      bus.start = 1'b0;
      reset = 1'b0;
      bus.resp_ready = 1'b1;
      if (!done_ok) check("run_timeout", 64'(bus.busy), 64'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int acc, seen;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.resp_ready = 1'b1;
      bus.challenge_top = '0;
      bus.challenge_btm = '0;
      foreach (next_bits[i]) next_bits[i] = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy",   64'(bus.busy),        64'd0);
      check("reset_valid",  64'(bus.resp_valid),  64'd0);
      check("reset_launch", 64'(bus.race_launch), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // All votes one, consumer always ready: 127-cycle latency, 7 pulses of 9.
      set_bits(7'b1111111);
      pulse_q.delete();
      launch(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, acc);
      wait_valid(1'b0, seen);
      check("latency_all_ones", 64'(seen - acc), 64'd127);
      check("resp_all_ones",    64'(bus.resp),   64'd1);
      check("stable_all_ones",  64'(bus.stable), 64'd1);
      drain();
      check("pulse_count", 64'(pulse_q.size()), 64'd7);
      foreach (pulse_q[i]) check("pulse_width", 64'(pulse_q[i]), 64'd9);

      // Votes 1,0,1,1,0,0,1 (first vote in bit 0): majority one, not unanimous.
      set_bits(7'b1001101);
      launch({$urandom, $urandom}, {$urandom, $urandom}, acc);
      wait_valid(1'b1, seen);
      check("resp_4ones",   64'(bus.resp),   64'd1);
      check("stable_4ones", 64'(bus.stable), 64'd0);
      drain();

      // Three ones out of seven: majority zero.
      set_bits(7'b0110010);
      launch({$urandom, $urandom}, {$urandom, $urandom}, acc);
      wait_valid(1'b0, seen);
      check("resp_3ones",   64'(bus.resp),   64'd0);
      check("stable_3ones", 64'(bus.stable), 64'd0);
      drain();

      // Consumer stalls for 20 cycles while start is pulsed; then ready and start together.
      bus.resp_ready = 1'b0;
      set_bits(7'b0000000);
      launch({$urandom, $urandom}, {$urandom, $urandom}, acc);
      wait_valid(1'b0, seen);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.start = 1'($urandom % 2);
      end
      check("stall_valid",  64'(bus.resp_valid), 64'd1);
      check("stall_resp",   64'(bus.resp),       64'd0);
      check("stall_stable", 64'(bus.stable),     64'd1);
      bus.resp_ready = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("exit_valid", 64'(bus.resp_valid), 64'd0);
      check("exit_busy",  64'(bus.busy),       64'd0);
      @(negedge clk);
      check("exit_start_ignored", 64'(bus.busy), 64'd0);

      // Reset during the third settle phase, then a full clean evaluation.
      set_bits(7'b1010101);
      launch({$urandom, $urandom}, {$urandom, $urandom}, acc);
      for (int i = 0; i < 100; i++) begin
         if (m_run && m_k == 2 * P + 3) break;
         @(negedge clk);
      end
      check("mid_settle_launch", 64'(bus.race_launch), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_launch",  64'(bus.race_launch), 64'd0);
      check("rst_busy",    64'(bus.busy),        64'd0);
      check("rst_sel_top", bus.sel_top,          64'd0);
      check("rst_sel_btm", bus.sel_btm,          64'd0);
      set_bits(7'b1110111);
      launch({$urandom, $urandom}, {$urandom, $urandom}, acc);
      wait_valid(1'b0, seen);
      check("latency_after_reset", 64'(seen - acc), 64'd127);
      check("resp_after_reset",    64'(bus.resp),   64'd1);
      drain();

      // Challenge inputs change mid-run; selects keep the latched values.
      bus.resp_ready = 1'b0;
      set_bits(7'b0101100);
      launch(64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, acc);
      repeat (30) @(negedge clk);
      bus.challenge_top = {$urandom, $urandom};
      bus.challenge_btm = {$urandom, $urandom};
      wait_valid(1'b0, seen);
      check("latched_sel_top", bus.sel_top, 64'hA5A5_A5A5_A5A5_A5A5);
      check("latched_sel_btm", bus.sel_btm, 64'h5A5A_5A5A_5A5A_5A5A);
      bus.resp_ready = 1'b1;
      drain();
      repeat (3) @(negedge clk);
      check("idle_sel_top", bus.sel_top, 64'hA5A5_A5A5_A5A5_A5A5);

      // Randomized evaluations with stalls, start noise, input churn and occasional resets.
      for (int r = 0; r < 12; r++) begin
         run_random();
         @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/arbiter_response_sampler.md
ARBITER_RESPONSE_SAMPLER -- requirements
Module: arbiter_response_sampler

Interface
REQ-001 SHALL have parameter CHAL_W, default 64: number of PDL switch stages and challenge width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: clock cycles per race settle phase and per relax phase, legal range 4..255.
REQ-003 SHALL have parameter VOTES, default 7: race evaluations per challenge, odd, legal range 1..255.
REQ-004 clk  input  1  single clock; every register is clocked on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one evaluation; sampled only in IDLE.
REQ-007 challenge_top  input  CHAL_W  top-path PDL select bits.
REQ-008 challenge_btm  input  CHAL_W  bottom-path PDL select bits.
REQ-009 sel_top  output  CHAL_W  registered select bits driven to the top PDL chain.
REQ-010 sel_btm  output  CHAL_W  registered select bits driven to the bottom PDL chain.
REQ-011 race_launch  output  1  registered edge driven into both chain inputs (i1 and i2).
REQ-012 arb_out  input  1  arbiter latch output, asynchronous to clk.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 resp  output  1  majority-voted response bit.
REQ-015 stable  output  1  high when all VOTES samples agreed.
REQ-016 resp_valid  output  1  response available.
REQ-017 resp_ready  input  1  consumer accepts the response.

Function
REQ-018 SHALL pass arb_out through a two-flop synchronizer; only the second flop's output is used.
REQ-019 SHALL implement states IDLE, LOAD, LAUNCH, SETTLE, SAMPLE, RELAX, DONE.
REQ-020 IDLE: start=1 SHALL latch challenge_top/btm into sel_top/sel_btm, clear vote and ones counters, and go to LOAD; start is ignored in all other states.
REQ-021 LOAD: one cycle for select settling, race_launch=0, then go to LAUNCH.
REQ-022 LAUNCH: race_launch SHALL go to 1 (registered), then go to SETTLE.
REQ-023 SETTLE: SHALL hold race_launch=1 for exactly SETTLE_CYCLES cycles, which covers race time and synchronizer latency, then go to SAMPLE.
REQ-024 SAMPLE: one cycle; SHALL add the synchronized arb_out to the ones counter and increment the vote counter, then go to RELAX.
REQ-025 RELAX: race_launch=0 for SETTLE_CYCLES cycles; then go to LAUNCH if vote counter < VOTES, else to DONE.
REQ-026 Per-vote period SHALL be 2*SETTLE_CYCLES+2 cycles; resp_valid SHALL rise exactly 1+VOTES*(2*SETTLE_CYCLES+2) cycles after the clock edge that accepts start (127 cycles with default parameters).
REQ-027 DONE entry SHALL set resp = (ones > VOTES/2), stable = (ones==0 or ones==VOTES), and resp_valid=1.
REQ-028 DONE: resp, stable and resp_valid SHALL hold unchanged until resp_ready=1; on that edge resp_valid goes to 0 and the state returns to IDLE.
REQ-029 resp_ready=1 in the same cycle resp_valid first rises SHALL complete the handshake in that cycle.
REQ-030 A start asserted in the cycle DONE exits SHALL be ignored; a new start is accepted only from IDLE on a following cycle.
REQ-031 Counters SHALL be 8 bits wide and saturate-free; the legal parameter ranges guarantee no wrap.
REQ-032 sel_top and sel_btm SHALL remain constant from LOAD through DONE.

Reset
REQ-033 reset=1 SHALL force, on the next edge and from any state including mid-race: state IDLE, race_launch=0, busy=0, resp=0, stable=0, resp_valid=0, sel_top=0, sel_btm=0, counters=0, synchronizer flops=0.
REQ-034 reset SHALL take priority over start and resp_ready.

Verification
REQ-035 Defaults, arb_out held at 1, start pulse, resp_ready=1 -> resp_valid rises 127 cycles after start with resp=1, stable=1, and 7 race_launch pulses of 9 cycles high each are observed.
REQ-036 arb_out = 1,0,1,1,0,0,1 at the 7 samples -> resp=1, stable=0; pattern with 3 ones -> resp=0, stable=0.
REQ-037 resp_ready held 0 for 20 cycles after resp_valid rises -> resp, stable and resp_valid stable throughout; start pulses during this window are ignored; resp_valid drops on the first edge with resp_ready=1.
REQ-038 reset asserted during the 3rd SETTLE phase -> next cycle race_launch=0, busy=0, sel_top=sel_btm=0; a subsequent start runs a full 7-vote evaluation.
REQ-039 challenge_top=64'hA5A5..., challenge_btm=64'h5A5A... with inputs changed mid-run -> sel_top/sel_btm keep the latched values until the next start accepted in IDLE.
